// File: rtl/program_loader.sv
// Boot-time loader: assembles a 16-bit word stream into 32-bit instructions,
// writes them to instruction memory, verifies the stream checksum, and
// releases the processor from reset only after a clean load.
//
// Ports:
//   clk          system clock, all state changes on the rising edge
//   rst          synchronous active-low reset
//   i_start      one-cycle load request (honoured in IDLE, DONE, ERR)
//   i_valid      i_data carries a stream word
//   i_data       16-bit stream word
//   o_ready      registered; loader accepts a word this cycle
//   o_mem_we     instruction-memory write strobe (one cycle per instruction)
//   o_mem_addr   instruction-memory word address
//   o_mem_wdata  instruction, {high half, low half}
//   o_cpu_hold   1 keeps the processor in reset
//   o_done       level, last load succeeded
//   o_error      level, last load failed
//   o_count      instructions written in the current/last load
module program_loader #(
    parameter int unsigned ADDR_W    = 12,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic              i_valid,
    input  logic [15:0]       i_data,
    output logic              o_ready,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [31:0]       o_mem_wdata,
    output logic              o_cpu_hold,
    output logic              o_done,
    output logic              o_error,
    output logic [ADDR_W:0]   o_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_HI,
        S_LO,
        S_CHK,
        S_DONE,
        S_ERR
    } state_e;

    // Largest instruction count that fits between BASE_ADDR and the top
    // of memory; wide enough that the comparison never truncates.
    localparam logic [32:0] LIMIT = (33'd1 << ADDR_W) - 33'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W+1)'(1);

    state_e              state_q, state_d;
    logic                ready_q, ready_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic [15:0]         n_q, n_d;
    logic [15:0]         hi_q, hi_d;
    logic [15:0]         acc_q, acc_d;

    logic                accept;
    logic                start_ok;
    logic                last_pair;
    logic [32:0]         cnt_next_w;

    assign accept     = i_valid & ready_q;
    assign start_ok   = i_start & ((state_q == S_IDLE) |
                                   (state_q == S_DONE) |
                                   (state_q == S_ERR));
    assign cnt_next_w = 33'(count_q) + 33'd1;
    // The instruction being completed by this LO accept is the N-th one.
    assign last_pair  = (cnt_next_w == 33'(n_q));

    // State register plus datapath registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            ready_q <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            count_q <= '0;
            n_q     <= '0;
            hi_q    <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            count_q <= count_d;
            n_q     <= n_d;
            hi_q    <= hi_d;
            acc_q   <= acc_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (i_start) begin
                    state_d = S_HDR;
                end
            end
            S_HDR: begin
                if (accept) begin
                    if (33'(i_data) > LIMIT) begin
                        state_d = S_ERR;
                    end else if (i_data == 16'd0) begin
                        state_d = S_CHK;
                    end else begin
                        state_d = S_HI;
                    end
                end
            end
            S_HI: begin
                if (accept) begin
                    state_d = S_LO;
                end
            end
            S_LO: begin
                if (accept) begin
                    state_d = last_pair ? S_CHK : S_HI;
                end
            end
            S_CHK: begin
                if (accept) begin
                    state_d = (i_data == acc_q) ? S_DONE : S_ERR;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Datapath next-state: word capture, checksum, write scheduling.
    always_comb begin
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        count_d = count_q;
        n_d     = n_q;
        hi_d    = hi_q;
        acc_d   = acc_q;
        // Ready is registered, so it follows the state being entered.
        ready_d = (state_d == S_HDR) | (state_d == S_HI) |
                  (state_d == S_LO)  | (state_d == S_CHK);
        if (start_ok) begin
            count_d = '0;
            acc_d   = '0;
        end
        if (accept) begin
            unique case (state_q)
                S_HDR: begin
                    n_d   = i_data;
                    acc_d = i_data;
                end
                S_HI: begin
                    hi_d  = i_data;
                    acc_d = acc_q ^ i_data;
                end
                S_LO: begin
                    acc_d   = acc_q ^ i_data;
                    we_d    = 1'b1;
                    // count_q is the 0-based index of this instruction.
                    addr_d  = BASE + count_q[ADDR_W-1:0];
                    wdata_d = {hi_q, i_data};
                    count_d = count_q + CNT_ONE;
                end
                default: begin
                end
            endcase
        end
    end

    // FSM outputs.
    always_comb begin
        o_done     = (state_q == S_DONE);
        o_error    = (state_q == S_ERR);
        o_cpu_hold = (state_q != S_DONE);
    end

    assign o_ready     = ready_q;
    assign o_mem_we    = we_q;
    assign o_mem_addr  = addr_q;
    assign o_mem_wdata = wdata_q;
    assign o_count     = count_q;

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard testbench for program_loader (ADDR_W=4, BASE_ADDR=0).
// Expected writes are queued at stimulus time and popped by a write monitor.
module tb_program_loader;

    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          i_start = 1'b0;
    logic          i_valid = 1'b0;
    logic [15:0]   i_data = 16'h0;
    logic          o_ready;
    logic          o_mem_we;
    logic [AW-1:0] o_mem_addr;
    logic [31:0]   o_mem_wdata;
    logic          o_cpu_hold;
    logic          o_done;
    logic          o_error;
    logic [AW:0]   o_count;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
        logic [AW:0]   cnt;
    } wr_t;

    wr_t exp_q[$];

    program_loader #(
        .ADDR_W(AW),
        .BASE_ADDR(0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .i_start(i_start),
        .i_valid(i_valid),
        .i_data(i_data),
        .o_ready(o_ready),
        .o_mem_we(o_mem_we),
        .o_mem_addr(o_mem_addr),
        .o_mem_wdata(o_mem_wdata),
        .o_cpu_hold(o_cpu_hold),
        .o_done(o_done),
        .o_error(o_error),
        .o_count(o_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Write monitor: every strobe must match the head of the scoreboard.
    initial begin : monitor
        wr_t e;
        forever begin
            @(negedge clk);
            if (o_mem_we === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_write addr=0x%0h data=0x%0h required=none",
                             o_mem_addr, o_mem_wdata);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_addr", 32'(o_mem_addr), 32'(e.addr));
                    chk("wr_data", o_mem_wdata, e.data);
                    chk("wr_count", 32'(o_count), 32'(e.cnt));
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "timeout");
    end

    task automatic start_load();
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
    endtask

    task automatic send_word(input logic [15:0] w, input bit gaps);
        int guard;
        int ng;
        ng = gaps ? int'($urandom_range(0, 2)) : 0;
        repeat (ng) begin
            i_valid = 1'b0;
            i_data  = 16'hDEAD;
            @(negedge clk);
        end
        i_valid = 1'b1;
        i_data  = w;
        guard   = 0;
        while (o_ready !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 20) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout word=0x%0h actual=not_ready required=ready", w);
        end
        @(negedge clk);
    endtask

    // Queue the writes the stream implies, then stream it.
    task automatic send_load(input logic [15:0] words[$], input bit gaps);
        wr_t e;
        int n;
        n = int'(words[0]);
        for (int i = 0; i < n && (2 + 2 * i) < words.size(); i++) begin
            e.addr = AW'(i);
            e.data = {words[1 + 2 * i], words[2 + 2 * i]};
            e.cnt  = (AW+1)'(i + 1);
            exp_q.push_back(e);
        end
        foreach (words[k]) send_word(words[k], gaps);
        i_valid = 1'b0;
    endtask

    task automatic wait_result();
        int guard;
        guard = 0;
        while (o_done !== 1'b1 && o_error !== 1'b1 && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 10) begin
            checks++;
            failures++;
            $display("FAIL result_timeout actual=busy required=done_or_error");
        end
    endtask

    task automatic check_status(input string tag, input logic done,
                                input logic err, input logic hold,
                                input int cnt);
        chk({tag, "_done"}, 32'(o_done), 32'(done));
        chk({tag, "_error"}, 32'(o_error), 32'(err));
        chk({tag, "_hold"}, 32'(o_cpu_hold), 32'(hold));
        chk({tag, "_count"}, 32'(o_count), 32'(cnt));
    endtask

    task automatic check_drained(input string tag);
        repeat (2) @(negedge clk);
        chk({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
    endtask

    logic [15:0] good[$];
    logic [15:0] bad[$];
    logic [15:0] empty[$];
    logic [15:0] full[$];
    logic [15:0] cs;

    initial begin
        good  = '{16'h0002, 16'h1234, 16'h5678, 16'hABCD, 16'hEF01, 16'h0082};
        bad   = '{16'h0002, 16'h1234, 16'h5678, 16'hABCD, 16'hEF01, 16'h0083};
        empty = '{16'h0000, 16'h0000};
        full.push_back(16'd16);
        cs = 16'd16;
        for (int i = 0; i < 16; i++) begin
            full.push_back(16'h1000 + 16'(i));
            full.push_back(16'h2000 + 16'(i * 3));
            cs = cs ^ (16'h1000 + 16'(i)) ^ (16'h2000 + 16'(i * 3));
        end
        full.push_back(cs);

        // Reset with start/valid asserted.
        rst = 1'b0;
        i_valid = 1'b1;
        i_start = 1'b1;
        i_data = 16'h0002;
        repeat (2) @(negedge clk);
        check_status("rst", 1'b0, 1'b0, 1'b1, 0);
        chk("rst_ready", 32'(o_ready), 32'd0);
        chk("rst_we", 32'(o_mem_we), 32'd0);
        rst = 1'b1;
        i_start = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_ready", 32'(o_ready), 32'd0);
        check_status("idle", 1'b0, 1'b0, 1'b1, 0);
        i_valid = 1'b0;

        // Good load.
        start_load();
        send_load(good, 1'b0);
        wait_result();
        check_status("good", 1'b1, 1'b0, 1'b0, 2);
        check_drained("good");

        // Stray valid words in DONE are ignored.
        i_valid = 1'b1;
        i_data = 16'h5555;
        repeat (3) @(negedge clk);
        i_valid = 1'b0;
        chk("done_ready", 32'(o_ready), 32'd0);
        check_status("done_idle", 1'b1, 1'b0, 1'b0, 2);

        // Bad checksum, then recovery.
        start_load();
        chk("restart_hold", 32'(o_cpu_hold), 32'd1);
        chk("restart_count", 32'(o_count), 32'd0);
        send_load(bad, 1'b0);
        wait_result();
        check_status("bad", 1'b0, 1'b1, 1'b1, 2);
        check_drained("bad");
        start_load();
        send_load(good, 1'b0);
        wait_result();
        check_status("recover", 1'b1, 1'b0, 1'b0, 2);
        check_drained("recover");

        // Empty image.
        start_load();
        send_load(empty, 1'b0);
        wait_result();
        check_status("empty", 1'b1, 1'b0, 1'b0, 0);
        check_drained("empty");

        // Overflow: 17 instructions cannot fit in 16 words.
        start_load();
        send_word(16'd17, 1'b0);
        i_valid = 1'b0;
        check_status("ovf", 1'b0, 1'b1, 1'b1, 0);
        chk("ovf_ready", 32'(o_ready), 32'd0);
        check_drained("ovf");

        // Exactly full memory.
        start_load();
        send_load(full, 1'b0);
        wait_result();
        check_status("full", 1'b1, 1'b0, 1'b0, 16);
        check_drained("full");

        // Gappy stream.
        start_load();
        send_load(good, 1'b1);
        wait_result();
        check_status("gaps", 1'b1, 1'b0, 1'b0, 2);
        check_drained("gaps");

        // Reset after first write and the next HI accept.
        exp_q.push_back('{addr: 4'd0, data: 32'h12345678, cnt: 5'd1});
        start_load();
        send_word(16'h0002, 1'b0);
        send_word(16'h1234, 1'b0);
        send_word(16'h5678, 1'b0);
        send_word(16'hABCD, 1'b0);
        rst = 1'b0;
        i_valid = 1'b0;
        @(negedge clk);
        chk("mid_we", 32'(o_mem_we), 32'd0);
        chk("mid_ready", 32'(o_ready), 32'd0);
        check_status("mid", 1'b0, 1'b0, 1'b1, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_sb_empty", 32'(exp_q.size()), 32'd0);
        start_load();
        send_load(good, 1'b0);
        wait_result();
        check_status("after_mid", 1'b1, 1'b0, 1'b0, 2);
        check_drained("after_mid");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Boot-time writer for the processor's 32-bit instruction memory; it fills the memory that the fetch stage reads.
- It receives a 16-bit word stream over a valid/ready handshake and assembles word pairs into 32-bit instructions.
- It writes each instruction to sequential instruction-memory addresses, then verifies a checksum.
- It holds the processor in reset until a load completes cleanly.

Parameters:
ADDR_W, 12, instruction-memory word-address width.
BASE_ADDR, 0, first instruction address written; must be < 2^ADDR_W.

Ports:
clk  input  1  system clock; all state updates on rising edge.
rst  input  1  synchronous, active-low reset (0 = reset, sampled on rising clk).
i_start  input  1  one-cycle load request; honoured only in IDLE, DONE, ERR.
i_valid  input  1  i_data holds a valid stream word.
i_data  input  16  stream word.
o_ready  output  1  loader can accept a word this cycle.
o_mem_we  output  1  instruction-memory write strobe, one cycle per instruction.
o_mem_addr  output  ADDR_W  write address.
o_mem_wdata  output  32  instruction to write, {high half, low half}.
o_cpu_hold  output  1  1 = keep processor in reset.
o_done  output  1  level; last load succeeded.
o_error  output  1  level; last load failed.
o_count  output  ADDR_W+1  instructions written in the current/last load.

Behaviour:
- Handshake: a word is accepted on a rising edge with i_valid=1 and o_ready=1.
  - o_ready is registered; it is 1 only in HDR, HI, LO and CHK.
  - i_valid while o_ready=0 is ignored; no words are dropped or queued.
- Stream format:
  - Header word N = instruction count.
  - Then N pairs: high half first, then low half.
  - Then one checksum word = XOR of the header and all 2N data words.
- Reset (rst=0 at an edge): state IDLE; o_ready=0, o_mem_we=0, o_mem_addr=0, o_mem_wdata=0, o_cpu_hold=1, o_done=0, o_error=0, o_count=0, checksum accumulator=0.
- States and transitions:
  - IDLE: i_start -> HDR; clear count and accumulator, clear done/error.
  - HDR: on accept, latch N, acc=word.
    - N > 2^ADDR_W-BASE_ADDR -> ERR.
    - N=0 -> CHK.
    - Otherwise -> HI.
  - HI: on accept, latch high half, acc^=word -> LO.
  - LO: on accept, acc^=word; schedule a write.
    - If this completes instruction N -> CHK, else -> HI.
  - CHK: on accept, word==acc -> DONE, else -> ERR.
  - DONE: o_done=1, o_cpu_hold=0; i_start -> HDR (hold reasserts on the same edge).
  - ERR: o_error=1, o_cpu_hold=1; i_start -> HDR.
- Write timing:
  - o_mem_we=1 for exactly the one cycle after each LO accept.
  - That cycle: o_mem_addr = BASE_ADDR + k (k = 0-based instruction index), o_mem_wdata = {hi, lo}.
  - o_count increments on the same edge that raises o_mem_we.
  - Back-to-back streaming (valid held high) gives one write every 2 cycles; a new HI accept in the write cycle is legal.
  - The write for the last instruction occurs in the first CHK cycle, before the checksum is accepted.
- o_mem_addr and o_mem_wdata hold their last values when o_mem_we=0.
- Address arithmetic is ADDR_W bits wide. The overflow check guarantees no wrap; N = 2^ADDR_W-BASE_ADDR is legal and writes through the top address.
- i_start outside IDLE/DONE/ERR is ignored. i_start in the same cycle as a data accept: the accept is processed and start is ignored.
- Reset mid-load: the next edge goes to IDLE with reset values.
  - A pending write strobe is cancelled (o_mem_we=0).
  - Memory already written is not restored.
- o_cpu_hold=0 only in DONE; the processor never runs on a partial or failed image.

Test Plan:
- Reset: rst=0 for 2 cycles with i_valid=1, i_start=1 -> o_cpu_hold=1, o_ready=0, o_mem_we=0, o_done=0, o_error=0, o_count=0; rst=1 with no i_start -> stays IDLE, no accepts.
- Good load (BASE_ADDR=0): i_start, then words 0x0002, 0x1234, 0x5678, 0xABCD, 0xEF01, 0x0082, valid held high.
  - Writes addr0=0x12345678, addr1=0xABCDEF01, each a 1-cycle o_mem_we.
  - Then o_done=1, o_cpu_hold=0, o_count=2.
- Bad checksum: same stream ending 0x0083 -> both writes occur, o_error=1, o_done=0, o_cpu_hold=1, o_count=2; then i_start plus the good stream -> DONE.
- Empty/overflow: N=0x0000, checksum 0x0000 -> DONE with no writes. With ADDR_W=4, BASE_ADDR=0:
  - N=17 -> ERR right after the header, no writes.
  - N=16 -> 16 writes at addresses 0..15, then DONE.
- Backpressure/gaps: i_valid toggling randomly through the good-load stream -> identical writes and result; no word accepted while o_ready=0.
- Mid-load reset: rst=0 after the first write and first HI accept -> IDLE, o_mem_we=0, o_count=0, hold=1; a restarted good load completes normally.
